// File: rtl/branch_enc_pkg.sv
// Shared types and constants for the branch instruction encoder.
// Opcode bit patterns and immediate widths live here so every file agrees.
package branch_enc_pkg;

  typedef enum logic [2:0] {
    KIND_B     = 3'd0,
    KIND_BL    = 3'd1,
    KIND_CBZ   = 3'd2,
    KIND_CBNZ  = 3'd3,
    KIND_BCOND = 3'd4
  } branch_kind_e;

  localparam logic [5:0] OPC_B      = 6'b000101;
  localparam logic [5:0] OPC_BL     = 6'b100101;
  localparam logic [7:0] OPC_CBZ    = 8'b1011_0100;
  localparam logic [7:0] OPC_CBNZ   = 8'b1011_0101;
  localparam logic [7:0] OPC_BCOND  = 8'b0101_0100;

  // Immediate widths in words; byte range is [-2^(W+1), 2^(W+1)-4].
  localparam int IMM26_W = 26;
  localparam int IMM19_W = 19;

endpackage

// File: rtl/branch_encoder_offset_fits.sv
// Checks that a word offset sign-extends from a FIELD_W-bit immediate and
// returns the truncated immediate field.
module offset_fits #(
  parameter int WORD_W  = 62,
  parameter int FIELD_W = 26
) (
  input  logic [WORD_W-1:0]  word_off_i,
  output logic               fits_o,
  output logic [FIELD_W-1:0] field_o
);

  localparam int HI_W = WORD_W - FIELD_W + 1;

  logic [HI_W-1:0] hi;

  // The field's own sign bit plus everything above it must be uniform.
  assign hi      = word_off_i[WORD_W-1:FIELD_W-1];
  assign fits_o  = (hi == '0) || (hi == '1);
  assign field_o = word_off_i[FIELD_W-1:0];

endmodule

// File: rtl/branch_encoder.sv
// Two-stage pipelined encoder turning (kind, pc, target, rt, cond) into a
// 32-bit branch instruction word, with valid/ready handshakes on both sides.
module branch_encoder
  import branch_enc_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_target,
  input  logic [4:0]        in_rt,
  input  logic [3:0]        in_cond,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic              out_err
);

  localparam int WORD_W = ADDR_W - 2;

  logic              ready_en_q;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_misalign_q;
  logic [2:0]        s1_kind_q;
  logic [WORD_W-1:0] s1_off_q;
  logic [4:0]        s1_rt_q;
  logic [3:0]        s1_cond_q;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic              out_err_q, out_err_d;

  logic              s2_adv, s1_adv, accept;
  logic [ADDR_W-1:0] diff;
  logic              fit26, fit19, ok;
  logic [25:0]       imm26;
  logic [18:0]       imm19;
  logic [31:0]       packed_w;

  // in_ready stays low until the first edge after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_en_q <= 1'b0;
    else          ready_en_q <= 1'b1;
  end

  always_comb begin
    s2_adv      = !out_valid_q || out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    in_ready    = ready_en_q && s1_adv;
    accept      = in_valid && in_ready;
    s1_valid_d  = s1_adv ? accept : s1_valid_q;
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
  end

  assign diff = in_target - in_pc;

  // ---- S1: offset subtraction and alignment check ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s1_valid_q <= 1'b0;
    else          s1_valid_q <= s1_valid_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_kind_q     <= in_kind;
      s1_off_q      <= diff[ADDR_W-1:2];
      s1_misalign_q <= (diff[1:0] != 2'b00);
      s1_rt_q       <= in_rt;
      s1_cond_q     <= in_cond;
    end
  end

  offset_fits #(.WORD_W(WORD_W), .FIELD_W(IMM26_W)) u_fit26 (
    .word_off_i (s1_off_q),
    .fits_o     (fit26),
    .field_o    (imm26)
  );

  offset_fits #(.WORD_W(WORD_W), .FIELD_W(IMM19_W)) u_fit19 (
    .word_off_i (s1_off_q),
    .fits_o     (fit19),
    .field_o    (imm19)
  );

  always_comb begin
    packed_w = '0;
    ok       = 1'b0;
    case (s1_kind_q)
      KIND_B:     begin packed_w = {OPC_B, imm26};                    ok = fit26; end
      KIND_BL:    begin packed_w = {OPC_BL, imm26};                   ok = fit26; end
      KIND_CBZ:   begin packed_w = {OPC_CBZ, imm19, s1_rt_q};         ok = fit19; end
      KIND_CBNZ:  begin packed_w = {OPC_CBNZ, imm19, s1_rt_q};        ok = fit19; end
      KIND_BCOND: begin packed_w = {OPC_BCOND, imm19, 1'b0, s1_cond_q}; ok = fit19; end
      default:    begin packed_w = '0;                                ok = 1'b0;  end
    endcase
    if (ok && !s1_misalign_q) begin
      out_instr_d = packed_w;
      out_err_d   = 1'b0;
    end else begin
      out_instr_d = '0;
      out_err_d   = 1'b1;
    end
  end

  // ---- S2: range check, packing, output registers ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s2_adv && s1_valid_q) begin
        out_instr_q <= out_instr_d;
        out_err_q   <= out_err_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_branch_encoder.sv
// Scoreboard bench for branch_encoder: a driver feeds queued vectors, the
// accept point pushes expected results, and a monitor pops and compares.
module tb_branch_encoder;
  import branch_enc_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [63:0] in_pc, in_target;
  logic [4:0]  in_rt;
  logic [3:0]  in_cond;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  typedef struct {
    logic [2:0]  kind;
    logic [63:0] pc;
    logic [63:0] tgt;
    logic [4:0]  rt;
    logic [3:0]  cond;
    logic [31:0] instr;
    logic        err;
  } stim_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_acc = 0;
  int    n_out = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic        prev_err;

  branch_encoder #(.ADDR_W(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_pc     (in_pc),
    .in_target (in_target),
    .in_rt     (in_rt),
    .in_cond   (in_cond),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] kind, input logic [63:0] pc, input logic [63:0] tgt,
                     input logic [4:0] rt, input logic [3:0] cond,
                     input logic [31:0] instr, input logic err);
    stim_t s;
    s.kind = kind; s.pc = pc; s.tgt = tgt; s.rt = rt; s.cond = cond;
    s.instr = instr; s.err = err;
    stim_q.push_back(s);
  endtask

  task automatic wait_acc(input int target, input string name);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (n_acc >= target) break;
    end
    if (n_acc < target) begin
      n_checks++; n_errors++;
      $display("FAIL %s: accepts %0d expected %0d (timeout)", name, n_acc, target);
    end
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (stim_q.size() == 0 && exp_q.size() == 0) break;
    end
    chk({name, "_drained"}, 64'(stim_q.size() + exp_q.size()), 64'd0);
  endtask

  // Driver: present the head of the stimulus queue after each rising edge.
  initial begin
    in_valid = 1'b0; in_kind = '0; in_pc = '0; in_target = '0; in_rt = '0; in_cond = '0;
    forever begin
      @(posedge clk); #1;
      if (reset_n && stim_q.size() > 0) begin
        in_valid  = 1'b1;
        in_kind   = stim_q[0].kind;
        in_pc     = stim_q[0].pc;
        in_target = stim_q[0].tgt;
        in_rt     = stim_q[0].rt;
        in_cond   = stim_q[0].cond;
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  // Monitor and accept tracker.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_instr", 64'(out_instr), 64'(prev_instr));
        chk("stall_err", 64'(out_err), 64'(prev_err));
      end
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_err   = out_err;
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_output: got instr=%h err=%b with no request pending",
                   out_instr, out_err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_instr", 64'(out_instr), 64'(e.instr));
          chk("out_err", 64'(out_err), 64'(e.err));
        end
      end
      if (in_valid && in_ready && stim_q.size() > 0) begin
        exp_t e;
        e.instr = stim_q[0].instr;
        e.err   = stim_q[0].err;
        exp_q.push_back(e);
        void'(stim_q.pop_front());
        n_acc++;
      end
    end
  end

  initial begin
    int base;
    int outs;
    reset_n   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    reset_n = 1'b1;
    #1 chk("rel_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel_in_ready_high", 64'(in_ready), 64'd1);

    // Latency: accepted at edge N, out_valid visible after edge N+1.
    base = n_acc;
    add(KIND_B, 64'h1000, 64'h1010, 5'd0, 4'd0, 32'h1400_0004, 1'b0);
    wait_acc(base + 1, "lat_accept");
    @(posedge clk); #1;
    chk("lat_s1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_s2", 64'(out_valid), 64'd1);
    drain("lat");

    // Directed vectors, streaming back-to-back.
    add(KIND_CBZ,   64'h2000, 64'h1FF8, 5'd3,  4'd0, 32'hB4FF_FFC3, 1'b0);
    add(KIND_BCOND, 64'h0, 64'h10_0000, 5'd0,  4'd5, 32'h0, 1'b1);
    add(KIND_BCOND, 64'h0, 64'hF_FFFC,  5'd0,  4'hA, 32'h547F_FFEA, 1'b0);
    add(KIND_BL,    64'h1000, 64'h1002, 5'd0,  4'd0, 32'h0, 1'b1);
    add(KIND_BL,    64'h1000, 64'h0,    5'd0,  4'd0, 32'h97FF_FC00, 1'b0);
    add(KIND_B,     64'h0, 64'h7FF_FFFC, 5'd0, 4'd0, 32'h15FF_FFFF, 1'b0);
    add(KIND_B,     64'h0, 64'h800_0000, 5'd0, 4'd0, 32'h0, 1'b1);
    add(KIND_B,     64'h800_0000, 64'h0, 5'd0, 4'd0, 32'h1600_0000, 1'b0);
    add(KIND_CBNZ,  64'h100, 64'h140,   5'd31, 4'd0, 32'hB500_021F, 1'b0);
    add(KIND_BCOND, 64'h10_0000, 64'h0, 5'd0,  4'd0, 32'h5480_0000, 1'b0);
    add(KIND_CBZ,   64'h0, 64'hFFFF_FFFF_FFEF_FFFC, 5'd1, 4'd0, 32'h0, 1'b1);
    add(3'd5,       64'h1000, 64'h1010, 5'd0,  4'd0, 32'h0, 1'b1);
    add(KIND_B, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 5'd0, 4'd0, 32'h1400_0008, 1'b0);
    drain("vectors");

    // Backpressure: only two requests fit while the output is stalled.
    @(posedge clk); #1;
    out_ready = 1'b0;
    base = n_acc;
    add(KIND_B,    64'h0, 64'h4,  5'd0, 4'd0, 32'h1400_0001, 1'b0);
    add(KIND_B,    64'h0, 64'h8,  5'd0, 4'd0, 32'h1400_0002, 1'b0);
    add(KIND_CBNZ, 64'h0, 64'h4,  5'd7, 4'd0, 32'hB500_0027, 1'b0);
    add(KIND_BL,   64'h0, 64'h3,  5'd0, 4'd0, 32'h0, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    chk("bp_accepts", 64'(n_acc - base), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("backpressure");

    // Reset while both stages hold requests: they must vanish.
    @(posedge clk); #1;
    out_ready = 1'b0;
    base = n_acc;
    add(KIND_B, 64'h0, 64'h40, 5'd0, 4'd0, 32'h1400_0010, 1'b0);
    add(KIND_B, 64'h0, 64'h80, 5'd0, 4'd0, 32'h1400_0020, 1'b0);
    add(KIND_B, 64'h0, 64'hC0, 5'd0, 4'd0, 32'h1400_0030, 1'b0);
    wait_acc(base + 2, "mid_accept");
    @(negedge clk); #1;
    chk("mid_full_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    stim_q.delete();
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_instr", 64'(out_instr), 64'd0);
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    outs = n_out;
    repeat (10) @(negedge clk);
    #1;
    chk("mid_no_output", 64'(n_out - outs), 64'd0);
    add(KIND_CBZ, 64'h2000, 64'h1FF8, 5'd3, 4'd0, 32'hB4FF_FFC3, 1'b0);
    drain("post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
